// File: rtl/program_table_ctrl.sv
// Program table controller: counts triggers per program and issues a dispatch
// beat (program id + instruction base) once a program reaches its threshold.
// Handshakes: a beat transfers on the rising edge where valid && ready are both high;
// the producer holds valid and the payload stable until that edge.
module program_table_ctrl #(
  parameter int PROGRAM_TABLE_ENTRY = 32,
  parameter int MAX_TRIGGER_VALUE   = 32,
  parameter int INST_ADDR_WIDTH     = 8,
  localparam int PW = $clog2(PROGRAM_TABLE_ENTRY),
  localparam int CW = $clog2(MAX_TRIGGER_VALUE),
  localparam int IW = INST_ADDR_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          program_id_vld_i,
  output logic          program_id_rdy_o,
  input  logic [PW-1:0] program_id_payload_i,
  input  logic          program_id_triggerd_i,
  input  logic          program_cfg_vld_i,
  input  logic [PW-1:0] program_cfg_id_i,
  input  logic [CW-1:0] program_cfg_threshold_i,
  input  logic [IW-1:0] program_cfg_inst_addr_i,
  output logic          dispatch_vld_o,
  input  logic          dispatch_rdy_i,
  output logic [PW-1:0] dispatch_program_o,
  output logic [IW-1:0] dispatch_inst_addr_o,
  output logic [CW-1:0] program_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_ISSUE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] id_q, id_d;
  logic          trig_q, trig_d;
  logic [CW-1:0] rd_count_q, rd_count_d;
  logic [CW-1:0] rd_thr_q, rd_thr_d;
  logic [IW-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] program_count_q, program_count_d;
  logic [PW-1:0] disp_prog_q, disp_prog_d;
  logic [IW-1:0] disp_addr_q, disp_addr_d;

  // Table storage is deliberately not reset.
  logic [CW-1:0] count_mem [PROGRAM_TABLE_ENTRY];
  logic [CW-1:0] thr_mem   [PROGRAM_TABLE_ENTRY];
  logic [IW-1:0] addr_mem  [PROGRAM_TABLE_ENTRY];

  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [CW-1:0] wr_count, wr_thr;
  logic [IW-1:0] wr_addr;
  logic          access_fire;
  logic [CW-1:0] thr_eff, count_inc;

  assign program_id_rdy_o     = (state_q == S_IDLE);
  assign dispatch_vld_o       = (state_q == S_ISSUE);
  assign dispatch_program_o   = disp_prog_q;
  assign dispatch_inst_addr_o = disp_addr_q;
  assign program_count_o      = program_count_q;

  assign access_fire = program_id_vld_i && program_id_rdy_o;
  assign thr_eff     = (rd_thr_q == '0) ? CW'(1) : rd_thr_q;
  assign count_inc   = rd_count_q + CW'(1);

  always_comb begin
    state_d         = state_q;
    id_d            = id_q;
    trig_d          = trig_q;
    rd_count_d      = rd_count_q;
    rd_thr_d        = rd_thr_q;
    rd_addr_d       = rd_addr_q;
    program_count_d = program_count_q;
    disp_prog_d     = disp_prog_q;
    disp_addr_d     = disp_addr_q;
    // The config port owns the single write port whenever it strobes.
    wr_en           = program_cfg_vld_i;
    wr_idx          = program_cfg_id_i;
    wr_count        = '0;
    wr_thr          = program_cfg_threshold_i;
    wr_addr         = program_cfg_inst_addr_i;

    case (state_q)
      S_IDLE: begin
        if (access_fire) begin
          id_d       = program_id_payload_i;
          trig_d     = program_id_triggerd_i;
          rd_count_d = count_mem[program_id_payload_i];
          rd_thr_d   = thr_mem[program_id_payload_i];
          rd_addr_d  = addr_mem[program_id_payload_i];
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        program_count_d = rd_count_q;
        state_d         = S_UPDATE;
      end
      S_UPDATE: begin
        if (!program_cfg_vld_i) begin
          if (!trig_q) begin
            state_d = S_IDLE;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = id_q;
            wr_thr  = rd_thr_q;
            wr_addr = rd_addr_q;
            if (count_inc == thr_eff) begin
              wr_count    = '0;
              disp_prog_d = id_q;
              disp_addr_d = rd_addr_q;
              state_d     = S_ISSUE;
            end else begin
              wr_count = count_inc;
              state_d  = S_IDLE;
            end
          end
        end
      end
      S_ISSUE: begin
        if (dispatch_rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= S_IDLE;
      id_q            <= '0;
      trig_q          <= 1'b0;
      rd_count_q      <= '0;
      rd_thr_q        <= '0;
      rd_addr_q       <= '0;
      program_count_q <= '0;
      disp_prog_q     <= '0;
      disp_addr_q     <= '0;
    end else begin
      state_q         <= state_d;
      id_q            <= id_d;
      trig_q          <= trig_d;
      rd_count_q      <= rd_count_d;
      rd_thr_q        <= rd_thr_d;
      rd_addr_q       <= rd_addr_d;
      program_count_q <= program_count_d;
      disp_prog_q     <= disp_prog_d;
      disp_addr_q     <= disp_addr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      count_mem[wr_idx] <= wr_count;
      thr_mem[wr_idx]   <= wr_thr;
      addr_mem[wr_idx]  <= wr_addr;
    end
  end

endmodule

// File: tb/tb_program_table_ctrl.sv
// Directed bench for program_table_ctrl: threshold counting, zero threshold,
// untriggered accesses, dispatch backpressure, config collision and reset in ISSUE.
module tb_program_table_ctrl;
  localparam int PW = 5;
  localparam int CW = 5;
  localparam int IW = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          program_id_vld_i;
  logic          program_id_rdy_o;
  logic [PW-1:0] program_id_payload_i;
  logic          program_id_triggerd_i;
  logic          program_cfg_vld_i;
  logic [PW-1:0] program_cfg_id_i;
  logic [CW-1:0] program_cfg_threshold_i;
  logic [IW-1:0] program_cfg_inst_addr_i;
  logic          dispatch_vld_o;
  logic          dispatch_rdy_i;
  logic [PW-1:0] dispatch_program_o;
  logic [IW-1:0] dispatch_inst_addr_o;
  logic [CW-1:0] program_count_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [PW+IW-1:0] exp_q[$];

  program_table_ctrl dut (
    .clk_i                  (clk_i),
    .rst_n_i                (rst_n_i),
    .program_id_vld_i       (program_id_vld_i),
    .program_id_rdy_o       (program_id_rdy_o),
    .program_id_payload_i   (program_id_payload_i),
    .program_id_triggerd_i  (program_id_triggerd_i),
    .program_cfg_vld_i      (program_cfg_vld_i),
    .program_cfg_id_i       (program_cfg_id_i),
    .program_cfg_threshold_i(program_cfg_threshold_i),
    .program_cfg_inst_addr_i(program_cfg_inst_addr_i),
    .dispatch_vld_o         (dispatch_vld_o),
    .dispatch_rdy_i         (dispatch_rdy_i),
    .dispatch_program_o     (dispatch_program_o),
    .dispatch_inst_addr_o   (dispatch_inst_addr_o),
    .program_count_o        (program_count_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every dispatch transfer must match the head of exp_q.
  always @(negedge clk_i) begin
    if (rst_n_i && dispatch_vld_o && dispatch_rdy_i) begin
      if (exp_q.size() == 0) begin
        chk("disp_unexpected", 32'(exp_q.size()), 1);
      end else begin
        logic [PW+IW-1:0] e;
        e = exp_q.pop_front();
        chk("disp_prog", 32'(dispatch_program_o), 32'(e[PW+IW-1:IW]));
        chk("disp_addr", 32'(dispatch_inst_addr_o), 32'(e[IW-1:0]));
      end
    end
  end

  // Drivers
  task automatic cfg(input logic [PW-1:0] id, input logic [CW-1:0] thr, input logic [IW-1:0] addr);
    @(posedge clk_i); #1;
    program_cfg_vld_i       = 1'b1;
    program_cfg_id_i        = id;
    program_cfg_threshold_i = thr;
    program_cfg_inst_addr_i = addr;
    @(posedge clk_i); #1;
    program_cfg_vld_i = 1'b0;
  endtask

  task automatic send_beat(input logic [PW-1:0] id, input logic trig);
    int n;
    @(posedge clk_i); #1;
    program_id_payload_i  = id;
    program_id_triggerd_i = trig;
    program_id_vld_i      = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!program_id_rdy_o && n < 50);
    chk("acc_rdy", 32'(program_id_rdy_o), 1);
    @(posedge clk_i); #1;
    program_id_vld_i      = 1'b0;
    program_id_triggerd_i = 1'b0;
  endtask

  // Full access: checks FETCH/UPDATE/T+3 behaviour, leaves bench at T+3 (or T+4) negedge.
  task automatic access(input logic [PW-1:0] id, input logic trig, input logic [CW-1:0] exp_cnt,
                        input logic exp_disp, input logic [IW-1:0] exp_addr);
    send_beat(id, trig);
    @(negedge clk_i);
    chk("fetch_rdy", 32'(program_id_rdy_o), 0);
    @(negedge clk_i);
    chk("upd_rdy", 32'(program_id_rdy_o), 0);
    chk("upd_count", 32'(program_count_o), 32'(exp_cnt));
    if (exp_disp) exp_q.push_back({id, exp_addr});
    @(negedge clk_i);
    chk("t3_disp_vld", 32'(dispatch_vld_o), 32'(exp_disp));
    chk("t3_rdy", 32'(program_id_rdy_o), 32'(!exp_disp));
    if (exp_disp && dispatch_rdy_i) begin
      @(negedge clk_i);
      chk("t4_rdy", 32'(program_id_rdy_o), 1);
      chk("t4_disp_vld", 32'(dispatch_vld_o), 0);
    end
  endtask

  initial begin
    rst_n_i                 = 1'b0;
    program_id_vld_i        = 1'b0;
    program_id_payload_i    = '0;
    program_id_triggerd_i   = 1'b0;
    program_cfg_vld_i       = 1'b0;
    program_cfg_id_i        = '0;
    program_cfg_threshold_i = '0;
    program_cfg_inst_addr_i = '0;
    dispatch_rdy_i          = 1'b1;

    #12;
    chk("rst_rdy", 32'(program_id_rdy_o), 1);
    chk("rst_disp_vld", 32'(dispatch_vld_o), 0);
    chk("rst_disp_prog", 32'(dispatch_program_o), 0);
    chk("rst_disp_addr", 32'(dispatch_inst_addr_o), 0);
    chk("rst_count", 32'(program_count_o), 0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // Threshold 3: dispatch on the third trigger.
    cfg(5'd5, 5'd3, 8'h40);
    access(5'd5, 1'b1, 5'd0, 1'b0, 8'h00);
    access(5'd5, 1'b1, 5'd1, 1'b0, 8'h00);
    access(5'd5, 1'b1, 5'd2, 1'b1, 8'h40);

    // Threshold 0 behaves as 1: every trigger dispatches.
    cfg(5'd2, 5'd0, 8'h11);
    access(5'd2, 1'b1, 5'd0, 1'b1, 8'h11);
    access(5'd2, 1'b1, 5'd0, 1'b1, 8'h11);

    // Untriggered access leaves the counter alone.
    cfg(5'd7, 5'd2, 8'h22);
    access(5'd7, 1'b0, 5'd0, 1'b0, 8'h00);
    access(5'd7, 1'b1, 5'd0, 1'b0, 8'h00);
    access(5'd7, 1'b1, 5'd1, 1'b1, 8'h22);

    // Dispatch backpressure for 4 cycles.
    cfg(5'd3, 5'd1, 8'h33);
    @(posedge clk_i); #1;
    dispatch_rdy_i = 1'b0;
    access(5'd3, 1'b1, 5'd0, 1'b1, 8'h33);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("stall_vld", 32'(dispatch_vld_o), 1);
      chk("stall_prog", 32'(dispatch_program_o), 3);
      chk("stall_addr", 32'(dispatch_inst_addr_o), 32'h33);
      chk("stall_rdy", 32'(program_id_rdy_o), 0);
    end
    @(posedge clk_i); #1;
    dispatch_rdy_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("unstall_rdy", 32'(program_id_rdy_o), 1);
    chk("unstall_vld", 32'(dispatch_vld_o), 0);

    // Config collision during UPDATE stretches it by one cycle.
    cfg(5'd4, 5'd5, 8'h44);
    send_beat(5'd4, 1'b1);
    @(posedge clk_i); #1;
    program_cfg_vld_i       = 1'b1;
    program_cfg_id_i        = 5'd9;
    program_cfg_threshold_i = 5'd2;
    program_cfg_inst_addr_i = 8'h99;
    @(negedge clk_i);
    chk("col_upd_count", 32'(program_count_o), 0);
    chk("col_upd_rdy", 32'(program_id_rdy_o), 0);
    @(posedge clk_i); #1;
    program_cfg_vld_i = 1'b0;
    @(negedge clk_i);
    chk("col_stall_rdy", 32'(program_id_rdy_o), 0);
    @(negedge clk_i);
    chk("col_done_rdy", 32'(program_id_rdy_o), 1);
    chk("col_done_vld", 32'(dispatch_vld_o), 0);
    access(5'd4, 1'b1, 5'd1, 1'b0, 8'h00);
    access(5'd9, 1'b1, 5'd0, 1'b0, 8'h00);
    access(5'd9, 1'b1, 5'd1, 1'b1, 8'h99);

    // Reset while in ISSUE drops the pending dispatch.
    cfg(5'd6, 5'd1, 8'h66);
    @(posedge clk_i); #1;
    dispatch_rdy_i = 1'b0;
    access(5'd6, 1'b1, 5'd0, 1'b1, 8'h66);
    #2;
    rst_n_i = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_issue_vld", 32'(dispatch_vld_o), 0);
    chk("rst_issue_prog", 32'(dispatch_program_o), 0);
    @(posedge clk_i); #1;
    rst_n_i        = 1'b1;
    dispatch_rdy_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_rdy", 32'(program_id_rdy_o), 1);
    chk("post_rst_vld", 32'(dispatch_vld_o), 0);
    chk("post_rst_count", 32'(program_count_o), 0);
    cfg(5'd1, 5'd1, 8'h5a);
    access(5'd1, 1'b1, 5'd0, 1'b1, 8'h5a);

    repeat (3) @(negedge clk_i);
    chk("exp_q_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_table_ctrl.md
# program_table_ctrl

Consumer end of the token→program access channel. Accepts program-access beats (program id plus trigger flag) from the token table controller and keeps a per-program trigger counter. When a program has collected its configured number of triggers, the block issues a dispatch beat carrying the program id and its instruction base address to the issue stage. Program entries are written through a single-cycle configuration port.

## Interface
- PROGRAM_TABLE_ENTRY, 32, number of program entries; id width PW = $clog2(PROGRAM_TABLE_ENTRY)
- MAX_TRIGGER_VALUE, 32, trigger counter range; counter width CW = $clog2(MAX_TRIGGER_VALUE)
- INST_ADDR_WIDTH, 8, instruction base address width (IW)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- program_id_vld_i  in  1  access beat valid
- program_id_rdy_o  out  1  access beat ready
- program_id_payload_i  in  PW  accessed program id
- program_id_triggerd_i  in  1  access carries a trigger (counter increment)
- program_cfg_vld_i  in  1  config write strobe, single cycle, always accepted
- program_cfg_id_i  in  PW  config entry index
- program_cfg_threshold_i  in  CW  triggers per dispatch
- program_cfg_inst_addr_i  in  IW  instruction base address
- dispatch_vld_o  out  1  dispatch beat valid
- dispatch_rdy_i  in  1  dispatch beat ready
- dispatch_program_o  out  PW  dispatched program id
- dispatch_inst_addr_o  out  IW  dispatched base address
- program_count_o  out  CW  counter value read by the most recent fetch

## Operation
- Entry layout {count[CW], threshold[CW], inst_addr[IW]}. Storage is a register array with a synchronous 1-cycle read and is not reset. A config write sets count=0, threshold=cfg, and inst_addr=cfg.
- Effective threshold: thr_eff = (threshold==0) ? 1 : threshold.
- FSM states: IDLE, FETCH, UPDATE, ISSUE.
  - IDLE: program_id_rdy_o=1 (combinational from state). On fire (vld&&rdy), latch the id and trigger flag, then go to FETCH.
  - FETCH: the table read completes; register count, threshold, and inst_addr; program_count_o takes the read count. Go to UPDATE.
  - UPDATE:
    - If the latched trigger flag is 0: no writeback; go to IDLE.
    - If triggered and count+1 == thr_eff: write back count=0, load the dispatch registers, and go to ISSUE.
    - If triggered otherwise: write back count+1 and go to IDLE.
    - Counter arithmetic is CW bits. Wrap cannot occur, because count < thr_eff ≤ 2^CW−1 by construction.
  - ISSUE: dispatch_vld_o=1. Hold dispatch_program_o and dispatch_inst_addr_o stable until dispatch_rdy_i; on that fire go to IDLE.
- Config collision: if program_cfg_vld_i is high in UPDATE, the config write takes the port. The FSM stays in UPDATE and retries the writeback the next cycle. The writeback uses values latched in FETCH, so it overwrites a config to the same index. Software must not reconfigure a program while it is being accessed.
- Config in IDLE, FETCH or ISSUE writes immediately. A config in FETCH to the same index does not alter the already-latched read.
- Only one access is in flight at a time. program_id_rdy_o=0 in FETCH, UPDATE and ISSUE.

## Timing
- Reset values: state=IDLE, program_id_rdy_o=1, dispatch_vld_o=0, dispatch_program_o=0, dispatch_inst_addr_o=0, program_count_o=0.
- Access fire at cycle T:
  - FETCH at T+1, UPDATE at T+2.
  - Non-dispatching access: rdy_o=1 again at T+3.
  - Dispatching access: dispatch_vld_o=1 from T+3. If dispatch_rdy_i is already high, the dispatch fires at T+3 and rdy_o=1 at T+4.
- Back-to-back throughput: one access per 3 cycles without dispatch; each UPDATE stall adds 1 cycle.
- Reset mid-operation: all registers return to reset values, and any pending dispatch or writeback is discarded. Table contents are undefined until reconfigured.

## Test plan
- Configure id 5 with threshold=3, addr=0x40. Send 3 triggered accesses to id 5 → no dispatch after the 1st and 2nd; after the 3rd, dispatch_vld_o at T+3 with program=5, addr=0x40; program_count_o=2 on the 3rd access.
- Configure id 2 with threshold=0, addr=0x11. Send one triggered access → immediate dispatch (program=2, addr=0x11). A second access also dispatches.
- Configure id 7 with threshold=2. Send an untriggered access → no writeback and program_count_o=0. Then send 2 triggered accesses → dispatch on the 2nd only.
- Create a dispatch with dispatch_rdy_i low for 4 cycles → vld, program and addr held stable; program_id_rdy_o=0 throughout. Raise rdy → dispatch fires, and program_id_rdy_o=1 the next cycle.
- Pulse program_cfg_vld_i (id 9) during the UPDATE of an access to id 4 → UPDATE extends by 1 cycle; id 9 is configured and id 4's count increments correctly.
- Assert rst_n_i while in ISSUE → dispatch_vld_o drops immediately and program_id_rdy_o=1 after release.
